// File: rtl/symbol_period_if.sv
// Bundle of the game-side handshake and display signals of symbol_period.
// The master side (the controller) drives the requests; the slave side
// (symbol_period) produces the period status and display values.
interface symbol_period_if;
    logic       tick1Hz;
    logic       startSig;
    logic [1:0] targetSym;
    logic       postSig;
    logic       running;
    logic [7:0] symbolSeg;
    logic [7:0] matchCount;
    logic [4:0] secLeft;

    modport master (
        output tick1Hz, startSig, targetSym,
        input  postSig, running, symbolSeg, matchCount, secLeft
    );

    modport slave (
        input  tick1Hz, startSig, targetSym,
        output postSig, running, symbolSeg, matchCount, secLeft
    );
endinterface

// File: rtl/symbol_period.sv
// Symbol period engine: after a start request it draws one pseudo-random
// symbol per 1 Hz tick for PERIOD_SEC ticks, shows it on a 7-segment digit,
// counts how many drawn symbols equal the player's target, then emits a
// one-cycle postSig pulse. The LFSR runs on across periods (never reseeded
// by a start) so consecutive periods show different sequences.
module symbol_period #(
    parameter int         PERIOD_SEC = 10,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic            Clk100M,
    input  logic            Reset,
    symbol_period_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;
    logic [7:0] seg;
    logic [7:0] match_cnt;
    logic [4:0] sec_left;
    logic       post;
    logic       run;
    logic       tick_run;
    logic       hit;

    // Eight-bit Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Active-low segment pattern for the four displayable symbols.
    function automatic logic [7:0] seg_map(input logic [1:0] sym);
        logic [7:0] pat;
        case (sym)
            2'd0:    pat = 8'hC0;
            2'd1:    pat = 8'hF9;
            2'd2:    pat = 8'hA4;
            default: pat = 8'hB0;
        endcase
        return pat;
    endfunction

    // Increment that sticks at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lfsr_next = lfsr_step(lfsr);
    assign tick_run  = (state == RUN) && bus.tick1Hz;
    assign hit       = (lfsr_next[1:0] == bus.targetSym);

    // State register.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; ticks in IDLE and starts in RUN are ignored.
    always_comb begin
        state_next = state;
        post       = 1'b0;
        run        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startSig) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (bus.tick1Hz && (sec_left == 5'd1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                post       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Period datapath: arm on start, draw/display/count/decrement on each running tick.
    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            lfsr      <= LFSR_SEED;
            seg       <= 8'hFF;
            match_cnt <= 8'd0;
            sec_left  <= 5'd0;
        end else if ((state == IDLE) && bus.startSig) begin
            seg       <= 8'hFF;
            match_cnt <= 8'd0;
            sec_left  <= 5'(PERIOD_SEC);
        end else if (tick_run) begin
            lfsr     <= lfsr_next;
            seg      <= seg_map(lfsr_next[1:0]);
            sec_left <= sec_left - 5'd1;
            if (hit) begin
                match_cnt <= sat_inc(match_cnt);
            end
        end
    end

    assign bus.postSig    = post;
    assign bus.running    = run;
    assign bus.symbolSeg  = seg;
    assign bus.matchCount = match_cnt;
    assign bus.secLeft    = sec_left;

endmodule

// File: tb/tb_symbol_period.sv
// Directed bench for symbol_period with a small reference model and an
// expectation queue: each running tick pushes the predicted outputs, which
// are popped and compared once the clock edge has been taken.
module tb_symbol_period;

    localparam int P = 3;

    typedef struct {
        logic [7:0] seg;
        logic [4:0] sec;
        logic [7:0] match;
        logic [7:0] lfsr;
        logic       post;
        logic       run;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;

    symbol_period_if bus ();
    symbol_period_if bus1 ();

    symbol_period #(.PERIOD_SEC(P), .LFSR_SEED(8'hA5)) dut (
        .Clk100M (clk),
        .Reset   (Reset),
        .bus     (bus.slave)
    );

    symbol_period #(.PERIOD_SEC(1), .LFSR_SEED(8'hA5)) dut1 (
        .Clk100M (clk),
        .Reset   (Reset),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    // Reference model state.
    logic [7:0] m_lfsr;
    logic [7:0] m_match;
    logic [7:0] m_seg;
    logic [4:0] m_sec;
    int         m_state;   // 0 idle, 1 run, 2 done

    function automatic logic [7:0] ref_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    function automatic logic [7:0] ref_seg(input logic [1:0] s);
        logic [7:0] t [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        return t[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive pulses before the edge, release and return at the following negedge.
    task automatic cycle(input logic t, input logic s);
        bus.tick1Hz  = t;
        bus.startSig = s;
        @(negedge clk);
        bus.tick1Hz  = 1'b0;
        bus.startSig = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".seg"},   bus.symbolSeg,  m_seg);
        chk({tag, ".sec"},   bus.secLeft,    m_sec);
        chk({tag, ".match"}, bus.matchCount, m_match);
        chk({tag, ".run"},   bus.running,    (m_state == 1));
        chk({tag, ".post"},  bus.postSig,    (m_state == 2));
        chk({tag, ".lfsr"},  dut.lfsr,       m_lfsr);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle(1'b0, 1'b0);
        Reset = 1'b0;
        m_lfsr = 8'hA5; m_match = 8'd0; m_seg = 8'hFF; m_sec = 5'd0; m_state = 0;
    endtask

    task automatic do_start(input logic with_tick, input string tag);
        m_match = 8'd0; m_sec = 5'(P); m_seg = 8'hFF; m_state = 1;
        cycle(with_tick, 1'b1);
        check_all(tag);
    endtask

    task automatic do_tick(input string tag);
        exp_t e;
        logic [1:0] sym;
        m_lfsr = ref_step(m_lfsr);
        sym    = m_lfsr[1:0];
        m_seg  = ref_seg(sym);
        m_sec  = m_sec - 5'd1;
        if (sym == bus.targetSym && m_match != 8'hFF) m_match = m_match + 8'd1;
        m_state = (m_sec == 0) ? 2 : 1;
        e = '{seg: m_seg, sec: m_sec, match: m_match, lfsr: m_lfsr,
              post: (m_state == 2), run: (m_state == 1)};
        q.push_back(e);
        cycle(1'b1, 1'b0);
        e = q.pop_front();
        chk({tag, ".seg"},   bus.symbolSeg,  e.seg);
        chk({tag, ".sec"},   bus.secLeft,    e.sec);
        chk({tag, ".match"}, bus.matchCount, e.match);
        chk({tag, ".lfsr"},  dut.lfsr,       e.lfsr);
        chk({tag, ".post"},  bus.postSig,    e.post);
        chk({tag, ".run"},   bus.running,    e.run);
    endtask

    task automatic do_idle(input logic t, input string tag);
        cycle(t, 1'b0);
        m_state = 0;
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        bus.tick1Hz = 1'b0; bus.startSig = 1'b0; bus.targetSym = 2'd2;
        bus1.tick1Hz = 1'b0; bus1.startSig = 1'b0; bus1.targetSym = 2'd2;
        @(negedge clk);
        do_reset();
        chk("rst.seg", bus.symbolSeg, 8'hFF);
        chk("rst.lfsr", dut.lfsr, 8'hA5);
        check_all("rst");
        do_idle(1'b1, "idle_tick_ignored");

        // Reference period: seed A5, target 2, three ticks.
        do_start(1'b0, "p1.start");
        do_tick("p1.t1");
        chk("p1.t1.lfsr_k", dut.lfsr, 8'h4A);
        chk("p1.t1.seg_k", bus.symbolSeg, 8'hA4);
        do_tick("p1.t2");
        chk("p1.t2.lfsr_k", dut.lfsr, 8'h95);
        chk("p1.t2.seg_k", bus.symbolSeg, 8'hF9);
        do_tick("p1.t3");
        chk("p1.t3.lfsr_k", dut.lfsr, 8'h2A);
        chk("p1.t3.match_k", bus.matchCount, 8'd2);
        chk("p1.t3.post_k", bus.postSig, 1'b1);
        do_idle(1'b0, "p1.after");
        chk("p1.after.sec_k", bus.secLeft, 5'd0);
        do_idle(1'b1, "p1.hold");

        // Second period continues the LFSR sequence from 2A.
        do_start(1'b0, "p2.start");
        do_tick("p2.t1");
        chk("p2.t1.lfsr_k", dut.lfsr, 8'h54);
        chk("p2.t1.seg_k", bus.symbolSeg, 8'hC0);
        chk("p2.t1.match_k", bus.matchCount, 8'd0);
        do_tick("p2.t2");
        // A start mid-period must not restart it.
        cycle(1'b0, 1'b1);
        check_all("p2.midstart");
        do_tick("p2.t3");
        do_idle(1'b0, "p2.after");
        do_idle(1'b0, "p2.after2");

        // Start and tick together: only the start is taken.
        bus.targetSym = 2'd1;
        do_start(1'b1, "p3.start_tick");
        chk("p3.start_tick.sec_k", bus.secLeft, 5'd3);
        do_tick("p3.t1");
        do_tick("p3.t2");
        // Reset aborts the period with no postSig.
        do_reset();
        chk("p3.abort.lfsr_k", dut.lfsr, 8'hA5);
        check_all("p3.abort");
        do_idle(1'b1, "p3.abort.idle1");
        do_idle(1'b1, "p3.abort.idle2");

        // PERIOD_SEC=1 instance: one tick, one symbol, then DONE.
        bus1.startSig = 1'b1;
        @(negedge clk);
        bus1.startSig = 1'b0;
        chk("p1s.start.run", bus1.running, 1'b1);
        chk("p1s.start.sec", bus1.secLeft, 5'd1);
        bus1.tick1Hz = 1'b1;
        @(negedge clk);
        bus1.tick1Hz = 1'b0;
        chk("p1s.tick.post", bus1.postSig, 1'b1);
        chk("p1s.tick.run", bus1.running, 1'b0);
        chk("p1s.tick.seg", bus1.symbolSeg, 8'hA4);
        chk("p1s.tick.match", bus1.matchCount, 8'd1);
        @(negedge clk);
        chk("p1s.after.post", bus1.postSig, 1'b0);

        // Saturation: preload the counter at full scale, then a matching tick.
        do_start(1'b0, "sat.start");
        force dut.match_cnt = 8'hFF;
        #1;
        release dut.match_cnt;
        m_match = 8'hFF;
        begin
            logic [7:0] nxt;
            nxt = ref_step(m_lfsr);
            bus.targetSym = nxt[1:0];
        end
        do_tick("sat.t1");
        chk("sat.t1.match_k", bus.matchCount, 8'hFF);
        begin
            logic [7:0] nxt;
            nxt = ref_step(m_lfsr);
            bus.targetSym = nxt[1:0];
        end
        do_tick("sat.t2");
        do_tick("sat.t3");
        do_idle(1'b0, "sat.after");

        // Reset during DONE truncates the pulse.
        do_start(1'b0, "rd.start");
        do_tick("rd.t1");
        do_tick("rd.t2");
        do_tick("rd.t3");
        do_reset();
        check_all("rd.reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/symbol_period.md
SYMBOL_PERIOD -- requirements
Module: symbol_period

Interface
REQ-001 Parameter PERIOD_SEC, default 10, number of 1 Hz ticks in one symbol period; legal range 1..31.
REQ-002 Parameter LFSR_SEED, default 8'hA5, LFSR value loaded at reset; SHALL be nonzero.
REQ-003 Clk100M  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 tick1Hz  input  1  one-cycle pulse in the Clk100M domain, once per second.
REQ-006 startSig  input  1  one-cycle request to begin a symbol period.
REQ-007 targetSym  input  2  symbol the player must count; sampled on every tick.
REQ-008 postSig  output  1  one-cycle pulse at period end; drives the post-period stage.
REQ-009 running  output  1  high while a period is in progress.
REQ-010 symbolSeg  output  8  active-low 7-seg pattern of the current symbol.
REQ-011 matchCount  output  8  number of generated symbols equal to targetSym in the current or last period.
REQ-012 secLeft  output  5  ticks remaining in the current period.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on startSig; on that edge matchCount clears to 0, secLeft loads PERIOD_SEC and symbolSeg goes to 8'hFF.
REQ-015 While in IDLE, the FSM SHALL ignore tick1Hz; if start and tick coincide, only the start is taken.
REQ-016 While in RUN, the FSM SHALL ignore startSig, so there is no restart mid-period.
REQ-017 On each tick in RUN, the LFSR SHALL advance: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-018 The new symbol SHALL be next[1:0]; symbolSeg updates on the same edge per REQ-019.
REQ-019 Symbol-to-segment map: 0 -> 8'hC0, 1 -> 8'hF9, 2 -> 8'hA4, 3 -> 8'hB0.
REQ-020 On a tick in RUN, if the new symbol equals targetSym, matchCount SHALL increment, saturating at 255 with no wrap.
REQ-021 On each tick in RUN, secLeft SHALL decrement by 1.
REQ-022 The tick that brings secLeft to 0 SHALL also move the FSM to DONE on the same edge.
REQ-023 DONE SHALL last exactly one cycle with postSig=1, then return to IDLE.
REQ-024 postSig SHALL be 0 in every other cycle.
REQ-025 Latency: postSig SHALL be high on the edge immediately after the final tick is sampled.
REQ-026 running SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-027 After DONE, matchCount and symbolSeg SHALL hold until the next startSig; secLeft SHALL read 0 in IDLE after a completed period.
REQ-028 The LFSR SHALL NOT be reseeded by startSig; the sequence continues across periods.
REQ-029 With PERIOD_SEC=1, a single tick SHALL produce one symbol followed by DONE.

Reset
REQ-030 While Reset is high: state=IDLE, lfsr=LFSR_SEED, postSig=0, running=0, symbolSeg=8'hFF, matchCount=0, secLeft=0.
REQ-031 Reset SHALL override every other input, including in RUN (the period is aborted with no postSig) and in DONE (the pulse is truncated).
REQ-032 After Reset deasserts, the block SHALL wait in IDLE for startSig.

Verification
REQ-033 PERIOD_SEC=3, seed 8'hA5, targetSym=2, start then 3 ticks:
  - lfsr sequence 4A, 95, 2A; symbols 2, 1, 2;
  - symbolSeg A4, F9, A4; secLeft 2, 1, 0;
  - matchCount=2; postSig high exactly one cycle after the 3rd tick; running then 0.
REQ-034 startSig and tick1Hz pulsed together in IDLE -> RUN entered, secLeft=3, symbolSeg=FF, lfsr still A5.
REQ-035 startSig pulsed mid-RUN -> no effect; secLeft and matchCount continue; exactly one postSig at the end.
REQ-036 Reset asserted after the 2nd tick -> the next cycle shows IDLE, matchCount=0, lfsr=A5; no postSig ever appears.
REQ-037 Second period without reset -> the first symbol comes from lfsr 2A -> 54 (symbol 0, seg C0); matchCount restarts from 0.
REQ-038 Force matchCount to 255 with targetSym matching -> matchCount stays 255.
